bouncing_sprites: RTL and testbench

Multi-sprite motion and hit-test engine for the VGA demo path. It holds N independently moving square sprites (the next generation of the single bouncing QR code), advances each one by a per-sprite step once per frame, bounces it off the screen edges, and optionally bounces sprites off each other. Each pixel cycle it reports which sprite, if any, covers the current raster coordinate, plus the sprite-local offset for the pattern ROM lookup. It sits between the VGA timing counters and the colour mux.

---
 rtl/bouncing_sprites.sv | 188 ++++++++++++++++++
 tb/tb_bouncing_sprites.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bouncing_sprites.sv
// Multi-sprite motion and hit-test engine: N square sprites that bounce off the screen edges, plus a registered raster hit test.
// Optional sprite-sprite bounce: define BOUNCING_SPRITES_COLLIDE_EN (undefined: sprites pass through, collide_evt stays 0).
module bouncing_sprites #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SPRITE_SIZE = 54,
    parameter int N_SPRITES   = 4,
    parameter int STEP_W      = 4,
    parameter int COORD_W     = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_tick,
    input  logic                           run,
    input  logic                           load_en,
    input  logic [$clog2(N_SPRITES)-1:0]   load_id,
    input  logic [COORD_W-1:0]             load_x,
    input  logic [COORD_W-1:0]             load_y,
    input  logic [1:0]                     load_dir,
    input  logic [COORD_W-1:0]             counter_x,
    input  logic [COORD_W-1:0]             counter_y,
    output logic                           hit,
    output logic [$clog2(N_SPRITES)-1:0]   hit_id,
    output logic [COORD_W-1:0]             local_x,
    output logic [COORD_W-1:0]             local_y,
    output logic [N_SPRITES*COORD_W-1:0]   pos_x,
    output logic [N_SPRITES*COORD_W-1:0]   pos_y,
    output logic [N_SPRITES-1:0]           bounce_evt,
    output logic [N_SPRITES-1:0]           collide_evt
);
    localparam int ID_W = $clog2(N_SPRITES);
    localparam int CW1  = COORD_W + 1;
    localparam logic [CW1-1:0] X_MAX = CW1'(H_RES - SPRITE_SIZE);
    localparam logic [CW1-1:0] Y_MAX = CW1'(V_RES - SPRITE_SIZE);
    localparam logic [CW1-1:0] SIZE  = CW1'(SPRITE_SIZE);

    logic [N_SPRITES-1:0][COORD_W-1:0] r_x, r_y, w_nx, w_ny, w_offx, w_offy;
    logic [N_SPRITES-1:0]              r_dir_x, r_dir_y, w_ndx, w_ndy;
    logic [N_SPRITES-1:0]              w_bnc, w_flip, w_load, w_in;
    logic [N_SPRITES-1:0]              r_bounce, r_collide;
    logic [COORD_W-1:0]                w_ld_x, w_ld_y;
    logic                              w_hit, r_hit;
    logic [ID_W-1:0]                   w_hit_id, r_hit_id;
    logic [COORD_W-1:0]                w_lx, w_ly, r_lx, r_ly;

    // Returns {bounced, new_dir, new_pos}; one bit of headroom keeps pos+step from wrapping.
    function automatic logic [COORD_W+1:0] move_axis(
        input logic [COORD_W-1:0] pos,
        input logic               dir,
        input logic [CW1-1:0]     stp,
        input logic [CW1-1:0]     lim
    );
        logic [CW1-1:0] ext;
        ext = {1'b0, pos};
        if (dir) begin
            if (ext + stp >= lim) begin
                move_axis = {1'b1, 1'b0, lim[COORD_W-1:0]};
            end else begin
                ext       = ext + stp;
                move_axis = {1'b0, 1'b1, ext[COORD_W-1:0]};
            end
        end else begin
            if (ext <= stp) begin
                move_axis = {1'b1, 1'b1, {COORD_W{1'b0}}};
            end else begin
                ext       = ext - stp;
                move_axis = {1'b0, 1'b0, ext[COORD_W-1:0]};
            end
        end
    endfunction

    assign w_ld_x = ({1'b0, load_x} > X_MAX) ? X_MAX[COORD_W-1:0] : load_x;
    assign w_ld_y = ({1'b0, load_y} > Y_MAX) ? Y_MAX[COORD_W-1:0] : load_y;

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_spr
        localparam logic [STEP_W-1:0] DX = STEP_W'(g + 1);
        localparam logic [STEP_W-1:0] DY = STEP_W'(N_SPRITES - g);
        logic [COORD_W+1:0] w_mx, w_my;

        // A pending collision flip is folded in before the step is taken.
        assign w_mx = move_axis(r_x[g], r_dir_x[g] ^ w_flip[g], {{(CW1-STEP_W){1'b0}}, DX}, X_MAX);
        assign w_my = move_axis(r_y[g], r_dir_y[g] ^ w_flip[g], {{(CW1-STEP_W){1'b0}}, DY}, Y_MAX);
        assign w_nx[g]   = w_mx[COORD_W-1:0];
        assign w_ny[g]   = w_my[COORD_W-1:0];
        assign w_ndx[g]  = w_mx[COORD_W];
        assign w_ndy[g]  = w_my[COORD_W];
        assign w_bnc[g]  = w_mx[COORD_W+1] | w_my[COORD_W+1];
        assign w_load[g] = load_en && (load_id == ID_W'(g));

        assign w_offx[g] = counter_x - r_x[g];
        assign w_offy[g] = counter_y - r_y[g];
        assign w_in[g]   = (counter_x >= r_x[g]) && ({1'b0, w_offx[g]} < SIZE) &&
                           (counter_y >= r_y[g]) && ({1'b0, w_offy[g]} < SIZE);
    end

`ifdef BOUNCING_SPRITES_COLLIDE_EN
    logic r_chk;

    always_comb begin
        w_flip = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            for (int j = 0; j < N_SPRITES; j++) begin
                if (r_chk && (i != j) &&
                    ({1'b0, r_x[i]} < {1'b0, r_x[j]} + SIZE) &&
                    ({1'b0, r_x[j]} < {1'b0, r_x[i]} + SIZE) &&
                    ({1'b0, r_y[i]} < {1'b0, r_y[j]} + SIZE) &&
                    ({1'b0, r_y[j]} < {1'b0, r_y[i]} + SIZE)) begin
                    w_flip[i] = 1'b1;
                end
            end
        end
    end
`else
    assign w_flip = '0;
`endif

    // Scan from the highest index down so the lowest covering sprite wins.
    always_comb begin
        w_hit    = 1'b0;
        w_hit_id = '0;
        w_lx     = '0;
        w_ly     = '0;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (w_in[i]) begin
                w_hit    = 1'b1;
                w_hit_id = ID_W'(i);
                w_lx     = w_offx[i];
                w_ly     = w_offy[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                r_x[i] <= COORD_W'(i * (SPRITE_SIZE + 8));
                r_y[i] <= '0;
            end
            r_dir_x   <= '1;
            r_dir_y   <= '1;
            r_bounce  <= '0;
            r_collide <= '0;
            r_hit     <= 1'b0;
            r_hit_id  <= '0;
            r_lx      <= '0;
            r_ly      <= '0;
`ifdef BOUNCING_SPRITES_COLLIDE_EN
            r_chk     <= 1'b0;
`endif
        end else begin
            r_bounce  <= '0;
            r_collide <= w_flip;
`ifdef BOUNCING_SPRITES_COLLIDE_EN
            r_chk     <= frame_tick & run;
`endif
            for (int i = 0; i < N_SPRITES; i++) begin
                if (w_load[i]) begin
                    r_x[i]     <= w_ld_x;
                    r_y[i]     <= w_ld_y;
                    r_dir_x[i] <= load_dir[1];
                    r_dir_y[i] <= load_dir[0];
                end else if (frame_tick && run) begin
                    r_x[i]      <= w_nx[i];
                    r_y[i]      <= w_ny[i];
                    r_dir_x[i]  <= w_ndx[i];
                    r_dir_y[i]  <= w_ndy[i];
                    r_bounce[i] <= w_bnc[i];
                end else if (w_flip[i]) begin
                    r_dir_x[i] <= ~r_dir_x[i];
                    r_dir_y[i] <= ~r_dir_y[i];
                end
            end
            r_hit    <= w_hit;
            r_hit_id <= w_hit_id;
            r_lx     <= w_lx;
            r_ly     <= w_ly;
        end
    end

    assign pos_x       = r_x;
    assign pos_y       = r_y;
    assign hit         = r_hit;
    assign hit_id      = r_hit_id;
    assign local_x     = r_lx;
    assign local_y     = r_ly;
    assign bounce_evt  = r_bounce;
    assign collide_evt = r_collide;
endmodule

// File: tb/tb_bouncing_sprites.sv
// Bench for bouncing_sprites: hit-test table, wall/freeze/collision sequences, then random stimulus against a reference model.
// Expectations follow BOUNCING_SPRITES_COLLIDE_EN the same way the design does.
module tb_bouncing_sprites;
    localparam int N    = 4;
    localparam int CW   = 10;
    localparam int SZ   = 54;
    localparam int HRES = 640;
    localparam int VRES = 480;
    localparam int XMAX = HRES - SZ;
    localparam int YMAX = VRES - SZ;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_tick = 1'b0;
    logic          run = 1'b0;
    logic          load_en = 1'b0;
    logic [1:0]    load_id = '0;
    logic [CW-1:0] load_x = '0, load_y = '0;
    logic [1:0]    load_dir = '0;
    logic [CW-1:0] counter_x = '0, counter_y = '0;
    logic          hit;
    logic [1:0]    hit_id;
    logic [CW-1:0] local_x, local_y;
    logic [N*CW-1:0] pos_x, pos_y;
    logic [N-1:0]  bounce_evt, collide_evt;

    int checks = 0;
    int errors = 0;

    // Reference model state: positions and directions as plain integers.
    int mx[N], my[N], mdx[N], mdy[N];
    int e_hit, e_id, e_lx, e_ly, e_bounce, e_collide;
`ifdef BOUNCING_SPRITES_COLLIDE_EN
    int m_chk = 0;
`endif

    typedef struct {
        int cx, cy, hit, id, lx, ly;
    } hit_vec_t;
    hit_vec_t tbl[9];

    logic [CW-1:0] exp_q[$];

    bouncing_sprites dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run),
        .load_en(load_en), .load_id(load_id), .load_x(load_x), .load_y(load_y),
        .load_dir(load_dir), .counter_x(counter_x), .counter_y(counter_y),
        .hit(hit), .hit_id(hit_id), .local_x(local_x), .local_y(local_y),
        .pos_x(pos_x), .pos_y(pos_y), .bounce_evt(bounce_evt), .collide_evt(collide_evt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void move(input int p_in, input int d_in, input int s, input int lim,
                                 output int p, output int d, output int b);
        b = 0;
        d = d_in;
        if (d_in != 0) begin
            p = p_in + s;
            if (p >= lim) begin p = lim; d = 0; b = 1; end
        end else begin
            p = p_in - s;
            if (p <= 0) begin p = 0; d = 1; b = 1; end
        end
    endfunction

    // One clock edge of the specified behaviour, evaluated on the inputs the DUT samples.
    task automatic model_edge();
        int fl[N];
        int upd, nd, b1, b2;
        e_hit = 0; e_id = 0; e_lx = 0; e_ly = 0; e_bounce = 0; e_collide = 0;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                mx[i] = i * (SZ + 8); my[i] = 0; mdx[i] = 1; mdy[i] = 1;
            end
`ifdef BOUNCING_SPRITES_COLLIDE_EN
            m_chk = 0;
`endif
            return;
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (counter_x >= mx[i] && counter_x < mx[i] + SZ &&
                counter_y >= my[i] && counter_y < my[i] + SZ) begin
                e_hit = 1; e_id = i; e_lx = counter_x - mx[i]; e_ly = counter_y - my[i];
            end
        end
        for (int i = 0; i < N; i++) fl[i] = 0;
`ifdef BOUNCING_SPRITES_COLLIDE_EN
        if (m_chk != 0) begin
            for (int i = 0; i < N; i++)
                for (int j = i + 1; j < N; j++)
                    if (iabs(mx[i] - mx[j]) < SZ && iabs(my[i] - my[j]) < SZ) begin
                        fl[i] = 1; fl[j] = 1;
                    end
        end
`endif
        for (int i = 0; i < N; i++) e_collide |= fl[i] << i;
        upd = (frame_tick && run) ? 1 : 0;
        for (int i = 0; i < N; i++) begin
            if (load_en && load_id == i) begin
                mx[i] = (load_x > XMAX) ? XMAX : int'(load_x);
                my[i] = (load_y > YMAX) ? YMAX : int'(load_y);
                mdx[i] = load_dir[1]; mdy[i] = load_dir[0];
            end else if (upd != 0) begin
                move(mx[i], mdx[i] ^ fl[i], i + 1, XMAX, mx[i], nd, b1); mdx[i] = nd;
                move(my[i], mdy[i] ^ fl[i], N - i, YMAX, my[i], nd, b2); mdy[i] = nd;
                if (b1 != 0 || b2 != 0) e_bounce |= 1 << i;
            end else if (fl[i] != 0) begin
                mdx[i] = 1 - mdx[i]; mdy[i] = 1 - mdy[i];
            end
        end
`ifdef BOUNCING_SPRITES_COLLIDE_EN
        m_chk = upd;
`endif
    endtask

    task automatic compare_all();
        check("hit", hit, e_hit);
        check("hit_id", hit_id, e_id);
        check("local_x", local_x, e_lx);
        check("local_y", local_y, e_ly);
        check("bounce_evt", bounce_evt, e_bounce);
        check("collide_evt", collide_evt, e_collide);
        for (int i = 0; i < N; i++) begin
            check($sformatf("pos_x[%0d]", i), pos_x[i*CW +: CW], mx[i]);
            check($sformatf("pos_y[%0d]", i), pos_y[i*CW +: CW], my[i]);
        end
    endtask

    task automatic do_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        do_cycle();
        frame_tick = 1'b0;
    endtask

    task automatic load(input int id, input int x, input int y, input int dir);
        load_en = 1'b1; load_id = 2'(id); load_x = CW'(x); load_y = CW'(y); load_dir = 2'(dir);
        do_cycle();
        load_en = 1'b0;
    endtask

    initial begin
        int snap_x[N], snap_y[N];
        int sel;

        tbl[0] = '{53, 53, 1, 0, 53, 53};
        tbl[1] = '{54, 0, 0, 0, 0, 0};
        tbl[2] = '{62, 10, 1, 1, 0, 10};
        tbl[3] = '{0, 0, 1, 0, 0, 0};
        tbl[4] = '{61, 0, 0, 0, 0, 0};
        tbl[5] = '{124, 53, 1, 2, 0, 53};
        tbl[6] = '{239, 0, 1, 3, 53, 0};
        tbl[7] = '{240, 0, 0, 0, 0, 0};
        tbl[8] = '{0, 54, 0, 0, 0, 0};

        // Reset
        reset = 1'b1;
        do_cycle();
        do_cycle();
        reset = 1'b0;
        run = 1'b1;
        check("rst s0 x", pos_x[0 +: CW], 0);
        check("rst s0 y", pos_y[0 +: CW], 0);
        check("rst s1 x", pos_x[CW +: CW], 62);
        check("rst s3 x", pos_x[3*CW +: CW], 186);
        check("rst s3 y", pos_y[3*CW +: CW], 0);
        check("rst hit", hit, 0);
        check("rst bounce", bounce_evt, 0);
        check("rst collide", collide_evt, 0);

        // Hit-test table, one-cycle latency
        for (int k = 0; k < 9; k++) begin
            counter_x = CW'(tbl[k].cx);
            counter_y = CW'(tbl[k].cy);
            do_cycle();
            check($sformatf("tbl%0d hit", k), hit, tbl[k].hit);
            check($sformatf("tbl%0d id", k), hit_id, tbl[k].id);
            check($sformatf("tbl%0d lx", k), local_x, tbl[k].lx);
            check($sformatf("tbl%0d ly", k), local_y, tbl[k].ly);
        end

        // Wall bounce of sprite0 on y (dy=4, y_max=426), ticks back to back
        for (int k = 0; k < 106; k++) tick();
        check("wall y after 106", pos_y[0 +: CW], 424);
        check("wall no bounce yet", bounce_evt[0], 0);
        tick();
        check("wall y tick107", pos_y[0 +: CW], 426);
        check("wall bounce tick107", bounce_evt[0], 1);
        do_cycle();
        check("wall bounce one cycle", bounce_evt[0], 0);
        tick();
        check("wall y tick108", pos_y[0 +: CW], 422);

        // Freeze and clamped load
        run = 1'b0;
        for (int i = 0; i < N; i++) begin snap_x[i] = mx[i]; snap_y[i] = my[i]; end
        for (int k = 0; k < 10; k++) begin
            tick();
            check("freeze bounce", bounce_evt, 0);
        end
        for (int i = 0; i < N; i++) begin
            check("freeze x", pos_x[i*CW +: CW], snap_x[i]);
            check("freeze y", pos_y[i*CW +: CW], snap_y[i]);
        end
        load(2, 700, 500, 0);
        check("clamp x", pos_x[2*CW +: CW], 586);
        check("clamp y", pos_y[2*CW +: CW], 426);

        // Sprite-sprite collision
        run = 1'b1;
        load(0, 100, 100, 3);
        load(1, 156, 100, 1);
        tick();
        check("coll s0 x", pos_x[0 +: CW], 101);
        check("coll s0 y", pos_y[0 +: CW], 104);
        check("coll s1 x", pos_x[CW +: CW], 154);
        check("coll s1 y", pos_y[CW +: CW], 103);
        check("coll evt t+1", collide_evt, 0);
        do_cycle();
`ifdef BOUNCING_SPRITES_COLLIDE_EN
        check("coll evt t+2", collide_evt, 3);
        exp_q.push_back(CW'(100)); exp_q.push_back(CW'(100));
        exp_q.push_back(CW'(156)); exp_q.push_back(CW'(100));
`else
        check("coll evt t+2", collide_evt, 0);
        exp_q.push_back(CW'(102)); exp_q.push_back(CW'(108));
        exp_q.push_back(CW'(152)); exp_q.push_back(CW'(106));
`endif
        tick();
        check("coll2 s0 x", pos_x[0 +: CW], exp_q.pop_front());
        check("coll2 s0 y", pos_y[0 +: CW], exp_q.pop_front());
        check("coll2 s1 x", pos_x[CW +: CW], exp_q.pop_front());
        check("coll2 s1 y", pos_y[CW +: CW], exp_q.pop_front());

        // Reset right after an overlapping update discards the pending flip
        load(0, 100, 100, 3);
        load(1, 156, 100, 1);
        tick();
        reset = 1'b1;
        do_cycle();
        reset = 1'b0;
        check("rst flip collide", collide_evt, 0);
        check("rst flip s1 x", pos_x[CW +: CW], 62);
        do_cycle();
        check("rst flip collide2", collide_evt, 0);

        // Random stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            reset      = ($urandom_range(0, 499) == 0);
            frame_tick = ($urandom_range(0, 3) == 0);
            run        = ($urandom_range(0, 7) != 0);
            load_en    = ($urandom_range(0, 15) == 0);
            load_id    = 2'($urandom_range(0, 3));
            load_x     = CW'($urandom_range(0, 1023));
            load_y     = CW'($urandom_range(0, 1023));
            load_dir   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                sel = $urandom_range(0, N - 1);
                counter_x = CW'(mx[sel] + $urandom_range(0, SZ + 2) - 1);
                counter_y = CW'(my[sel] + $urandom_range(0, SZ + 2) - 1);
            end else begin
                counter_x = CW'($urandom_range(0, HRES - 1));
                counter_y = CW'($urandom_range(0, VRES - 1));
            end
            do_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
